// File: rtl/core_seq_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : core_seq_ctl
//  Purpose  : Multi-cycle control sequencer for the simple core datapath.
//             Steps each instruction through FETCH, DECODE, EXEC, MEM, MULW
//             and WB, drives the ALU control, the register/PC/IR write
//             enables and the memory request handshake, and times the
//             multi-cycle multiplier.
//  Ports    : clk          core clock, rising edge
//             reset        synchronous, active-high reset
//             instId[2:0]  instruction class from decode (sampled in DECODE)
//             funct[2:0]   ALU function field of the current instruction
//             branchTaken  branch condition result, valid in EXEC
//             memAck       memory completes the current request this cycle
//             memReq       memory request
//             memWe        1 = write (store), 0 = read
//             irWe         load instruction register
//             pcWe         update PC
//             pcSel        0 = PC+4, 1 = branch target
//             aluCtl[2:0]  ALU function select
//             regWe        register file write
//             mulStart     one-cycle multiplier start pulse
//             illegal      one-cycle pulse on an undefined class
//  Option   : CORE_SEQ_TRACE_EN adds stateText[47:0] (ASCII state name) and
//             retireCnt[31:0] (completed instruction counter).
//  Revision : 1.0  initial release
// ============================================================================
module core_seq_ctl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] instId,
   input  logic [2:0] funct,
   input  logic       branchTaken,
   input  logic       memAck,
   output logic       memReq,
   output logic       memWe,
   output logic       irWe,
   output logic       pcWe,
   output logic       pcSel,
   output logic [2:0] aluCtl,
   output logic       regWe,
   output logic       mulStart,
   output logic       illegal
`ifdef CORE_SEQ_TRACE_EN
   ,
   output logic [47:0] stateText,
   output logic [31:0] retireCnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_MULW   = 3'd5,
      S_WB     = 3'd6
   } state_t;

   localparam logic [2:0] CLS_ALUI   = 3'd0;
   localparam logic [2:0] CLS_ALUR   = 3'd1;
   localparam logic [2:0] CLS_SHRO   = 3'd2;
   localparam logic [2:0] CLS_LOAD   = 3'd3;
   localparam logic [2:0] CLS_STORE  = 3'd4;
   localparam logic [2:0] CLS_BRANCH = 3'd5;
   localparam logic [2:0] CLS_MUL    = 3'd6;

   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;

   // Counter runs MUL_CYCLES-1 down to 0, so MULW lasts exactly MUL_CYCLES.
   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);

   state_t     state;
   logic [2:0] cls;
   logic [7:0] mul_cnt;

   // ------------------------------------------------------------------
   // State sequencing
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cls     <= 3'd0;
         mul_cnt <= 8'd0;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (memAck) state <= S_DECODE;
            end
            S_DECODE: begin
               cls   <= instId;
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (cls)
                  CLS_ALUI, CLS_ALUR, CLS_SHRO: state <= S_WB;
                  CLS_LOAD, CLS_STORE:          state <= S_MEM;
                  CLS_MUL: begin
                     mul_cnt <= MUL_LOAD;
                     state   <= S_MULW;
                  end
                  // BRANCH and the undefined class both retire here.
                  default: state <= S_FETCH;
               endcase
            end
            S_MULW: begin
               if (mul_cnt != 8'd0) mul_cnt <= mul_cnt - 8'd1;
               else                 state   <= S_WB;
            end
            S_MEM: begin
               if (memAck) state <= (cls == CLS_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode from registered state and latched class. reset forces
   // every output low in the same cycle so a pending request drops at once.
   // ------------------------------------------------------------------
   always_comb begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      irWe     = 1'b0;
      pcWe     = 1'b0;
      pcSel    = 1'b0;
      aluCtl   = 3'b000;
      regWe    = 1'b0;
      mulStart = 1'b0;
      illegal  = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               memReq = 1'b1;
               irWe   = memAck;
               pcWe   = memAck;
            end
            S_EXEC: begin
               case (cls)
                  CLS_ALUI, CLS_ALUR, CLS_SHRO: aluCtl = funct;
                  CLS_LOAD, CLS_STORE:          aluCtl = ALU_ADD;
                  CLS_BRANCH: begin
                     aluCtl = ALU_SUB;
                     pcWe   = branchTaken;
                     pcSel  = 1'b1;
                  end
                  CLS_MUL: mulStart = 1'b1;
                  default: illegal  = 1'b1;
               endcase
            end
            S_MEM: begin
               memReq = 1'b1;
               memWe  = (cls == CLS_STORE);
               aluCtl = ALU_ADD;
            end
            S_WB:    regWe = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CORE_SEQ_TRACE_EN
   logic retire;

   // An instruction retires on WB exit, BRANCH/illegal EXEC exit or STORE
   // memory completion.
   always_comb begin
      retire = 1'b0;
      if (!reset) begin
         case (state)
            S_WB:   retire = 1'b1;
            S_EXEC: retire = (cls == CLS_BRANCH) || (cls == 3'd7);
            S_MEM:  retire = memAck && (cls == CLS_STORE);
            default: retire = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       retireCnt <= 32'd0;
      else if (retire) retireCnt <= retireCnt + 32'd1;
   end

   always_comb begin
      case (state)
         S_IDLE:   stateText = "IDLE  ";
         S_FETCH:  stateText = "FETCH ";
         S_DECODE: stateText = "DECODE";
         S_EXEC:   stateText = "EXEC  ";
         S_MEM:    stateText = "MEM   ";
         S_MULW:   stateText = "MULW  ";
         S_WB:     stateText = "WB    ";
         default:  stateText = "??????";
      endcase
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_seq_ctl
//  Purpose  : Self-checking bench for core_seq_ctl. Expected per-cycle output
//             vectors are derived from the instruction class and pushed to a
//             scoreboard queue as stimulus is driven, then popped and
//             compared on the falling edge. Two instances: MUL_CYCLES=4 and
//             MUL_CYCLES=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_seq_ctl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1;
   logic [2:0] instId, funct;
   logic       branchTaken, memAck;

   logic       memReq0, memWe0, irWe0, pcWe0, pcSel0, regWe0, mulStart0, illegal0;
   logic [2:0] aluCtl0;
   logic       memReq1, memWe1, irWe1, pcWe1, pcSel1, regWe1, mulStart1, illegal1;
   logic [2:0] aluCtl1;
`ifdef CORE_SEQ_TRACE_EN
   logic [47:0] st0, st1;
   logic [31:0] rc0, rc1;
`endif

   core_seq_ctl #(.MUL_CYCLES(4)) dut (
      .clk(clk), .reset(rst0), .instId(instId), .funct(funct),
      .branchTaken(branchTaken), .memAck(memAck),
      .memReq(memReq0), .memWe(memWe0), .irWe(irWe0), .pcWe(pcWe0),
      .pcSel(pcSel0), .aluCtl(aluCtl0), .regWe(regWe0),
      .mulStart(mulStart0), .illegal(illegal0)
`ifdef CORE_SEQ_TRACE_EN
      , .stateText(st0), .retireCnt(rc0)
`endif
   );

   core_seq_ctl #(.MUL_CYCLES(1)) dut1 (
      .clk(clk), .reset(rst1), .instId(instId), .funct(funct),
      .branchTaken(branchTaken), .memAck(memAck),
      .memReq(memReq1), .memWe(memWe1), .irWe(irWe1), .pcWe(pcWe1),
      .pcSel(pcSel1), .aluCtl(aluCtl1), .regWe(regWe1),
      .mulStart(mulStart1), .illegal(illegal1)
`ifdef CORE_SEQ_TRACE_EN
      , .stateText(st1), .retireCnt(rc1)
`endif
   );

   // Output vector: {memReq, memWe, irWe, pcWe, pcSel, aluCtl, regWe, mulStart, illegal}
   logic [10:0] v0, v1;
   assign v0 = {memReq0, memWe0, irWe0, pcWe0, pcSel0, aluCtl0, regWe0, mulStart0, illegal0};
   assign v1 = {memReq1, memWe1, irWe1, pcWe1, pcSel1, aluCtl1, regWe1, mulStart1, illegal1};

   logic        sel;
   logic [10:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_ret  = 0;

   task automatic check_val(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic logic [10:0] ov(input logic rq, input logic we, input logic ir,
                                      input logic pc, input logic ps, input logic [2:0] alu,
                                      input logic rw, input logic ms, input logic il);
      return {rq, we, ir, pc, ps, alu, rw, ms, il};
   endfunction

   // One clock cycle: drive inputs, push expectation, compare on falling edge.
   task automatic cyc(input string tag, input logic ack, input logic [2:0] id, input logic [10:0] exp);
      logic [10:0] e;
      memAck = ack;
      instId = id;
      exp_q.push_back(exp);
      @(negedge clk);
      e = exp_q.pop_front();
      check_val(tag, {37'd0, (sel ? v1 : v0)}, {37'd0, e});
      @(posedge clk);
      #1;
   endtask

   // Full instruction from FETCH to retirement. instId carries junk outside
   // DECODE and memAck is high in cycles where it must be ignored.
   task automatic instr(input logic [2:0] cls, input logic [2:0] fn, input logic bt,
                        input int fwait, input int mwait, input int mulc);
      logic [2:0] junk;
      junk        = cls ^ 3'b101;
      funct       = fn;
      branchTaken = bt;
      for (int i = 0; i < fwait; i++) cyc("fetch_wait", 1'b0, junk, ov(1,0,0,0,0,3'b000,0,0,0));
      cyc("fetch_ack", 1'b1, junk, ov(1,0,1,1,0,3'b000,0,0,0));
      cyc("decode", 1'b1, cls, 11'd0);
      case (cls)
         3'd0, 3'd1, 3'd2: begin
            cyc("exec_alu", 1'b1, junk, ov(0,0,0,0,0,fn,0,0,0));
            cyc("wb", 1'b1, junk, ov(0,0,0,0,0,3'b000,1,0,0));
         end
         3'd3, 3'd4: begin
            cyc("exec_addr", 1'b1, junk, ov(0,0,0,0,0,3'b100,0,0,0));
            for (int i = 0; i < mwait; i++)
               cyc("mem_wait", 1'b0, junk, ov(1,(cls == 3'd4),0,0,0,3'b100,0,0,0));
            cyc("mem_ack", 1'b1, junk, ov(1,(cls == 3'd4),0,0,0,3'b100,0,0,0));
            if (cls == 3'd3) cyc("wb_load", 1'b1, junk, ov(0,0,0,0,0,3'b000,1,0,0));
         end
         3'd5: cyc("exec_branch", 1'b1, junk, ov(0,0,0,bt,1,3'b110,0,0,0));
         3'd6: begin
            cyc("exec_mul", 1'b1, junk, ov(0,0,0,0,0,3'b000,0,1,0));
            for (int i = 0; i < mulc; i++) cyc("mulw", 1'b1, junk, 11'd0);
            cyc("wb_mul", 1'b1, junk, ov(0,0,0,0,0,3'b000,1,0,0));
         end
         default: cyc("exec_illegal", 1'b1, junk, ov(0,0,0,0,0,3'b000,0,0,1));
      endcase
      exp_ret++;
   endtask

   initial begin
      sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
      instId = 3'd0; funct = 3'd0; branchTaken = 1'b0; memAck = 1'b1;
      @(posedge clk);
      #1;
      // Reset held 3 cycles with memAck high: everything quiet.
      for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 3'd0, 11'd0);
      rst0 = 1'b0;
`ifdef CORE_SEQ_TRACE_EN
      @(negedge clk);
      check_val("state_idle", st0, "IDLE  ");
      @(posedge clk);
      #1;
`else
      cyc("idle", 1'b1, 3'd0, 11'd0);
`endif
      instr(3'd1, 3'b011, 1'b0, 0, 0, 0);   // ALUR, funct 011
      instr(3'd3, 3'b000, 1'b0, 1, 2, 0);   // LOAD, fetch wait 1, mem wait 2
      instr(3'd4, 3'b111, 1'b0, 0, 0, 0);   // STORE, zero wait
      instr(3'd5, 3'b000, 1'b1, 0, 0, 0);   // BRANCH taken
      instr(3'd5, 3'b000, 1'b0, 0, 0, 0);   // BRANCH not taken
      instr(3'd6, 3'b001, 1'b0, 0, 0, 4);   // MUL, 4 MULW cycles
      instr(3'd7, 3'b000, 1'b1, 0, 0, 0);   // undefined class
      instr(3'd0, 3'b101, 1'b0, 2, 0, 0);   // ALUI
      instr(3'd2, 3'b010, 1'b0, 0, 0, 0);   // SHRO
      instr(3'd4, 3'b000, 1'b0, 0, 3, 0);   // STORE with 3 wait cycles
`ifdef CORE_SEQ_TRACE_EN
      check_val("retire_cnt", {16'd0, rc0}, 48'(exp_ret));
`endif

      // MUL aborted by reset while the countdown sits at 2.
      funct = 3'd0;
      cyc("abort_fetch", 1'b1, 3'd0, ov(1,0,1,1,0,3'b000,0,0,0));
      cyc("abort_decode", 1'b1, 3'd6, 11'd0);
      cyc("abort_exec", 1'b1, 3'd0, ov(0,0,0,0,0,3'b000,0,1,0));
      cyc("abort_mulw3", 1'b1, 3'd0, 11'd0);
`ifdef CORE_SEQ_TRACE_EN
      check_val("retire_abort", {16'd0, rc0}, 48'(exp_ret));
      exp_ret = 0;
`endif
      rst0 = 1'b1;
      cyc("abort_rst_a", 1'b1, 3'd0, 11'd0);
      cyc("abort_rst_b", 1'b1, 3'd0, 11'd0);
      rst0 = 1'b0;
      cyc("abort_idle", 1'b1, 3'd0, 11'd0);
      instr(3'd6, 3'b000, 1'b0, 0, 0, 4);   // full MUL after abort: no stale count
`ifdef CORE_SEQ_TRACE_EN
      check_val("retire_after_rst", {16'd0, rc0}, 48'(exp_ret));
`endif

      // Switch to the MUL_CYCLES=1 instance.
      rst0 = 1'b1;
      rst1 = 1'b0;
      sel  = 1'b1;
      cyc("idle1", 1'b1, 3'd0, 11'd0);
      instr(3'd6, 3'b000, 1'b0, 0, 0, 1);   // MUL, single MULW cycle
      instr(3'd1, 3'b110, 1'b0, 0, 0, 0);   // ALUR after it
      instr(3'd6, 3'b000, 1'b0, 1, 0, 1);

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
